hazard_unit_ctrl: RTL and testbench

- Pipeline hazard detection unit for the PoliRISC-V core.
- Compares decode-stage source registers against the EX and MEM destination registers, using the hazard policy chosen by the pipeline.
- Drives combinational stall (IF, ID) and flush (ID, EX) controls.
- Keeps a registered, saturating count of stall cycles for performance monitoring.

---
 rtl/hazard_unit_ctrl_if.sv | 34 +++
 rtl/hazard_unit_ctrl.sv | 72 +++++++
 tb/tb_hazard_unit_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_ctrl_if.sv
// Hazard-detection bus between the pipeline (master) and the hazard unit (slave).
// Carries the decode/EX/MEM register-usage info in and the stall/flush controls out.
interface hazard_unit_ctrl_if;
  logic [1:0] hazard_type;
  logic       rs_used;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic [4:0] rd_ex;
  logic [4:0] rd_mem;
  logic       reg_we_ex;
  logic       reg_we_mem;
  logic       mem_rd_en_ex;
  logic       mem_rd_en_mem;
  logic       store_id;
  logic       rd_complete_ex;
  logic       stall_if;
  logic       stall_id;
  logic       flush_id;
  logic       flush_ex;

  modport master (
    output hazard_type, rs_used, rs1_id, rs2_id, rd_ex, rd_mem,
           reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem,
           store_id, rd_complete_ex,
    input  stall_if, stall_id, flush_id, flush_ex
  );

  modport slave (
    input  hazard_type, rs_used, rs1_id, rs2_id, rd_ex, rd_mem,
           reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem,
           store_id, rd_complete_ex,
    output stall_if, stall_id, flush_id, flush_ex
  );
endinterface

// File: rtl/hazard_unit_ctrl.sv
// PoliRISC-V hazard detection: combinational stall/flush controls plus a
// saturating count of stalled cycles for performance monitoring.
module hazard_unit_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  hazard_unit_ctrl_if.slave    hz,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [1:0] NO_HAZARD        = 2'd0;
  localparam logic [1:0] HAZARD_DECODE    = 2'd1;
  localparam logic [1:0] HAZARD_EXECUTE   = 2'd2;
  localparam logic [1:0] HAZARD_EXCEPTION = 2'd3;

  // x0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd,
                                     input logic we, input logic en);
    return (rs == rd) && (rd != 5'd0) && we && en;
  endfunction

  function automatic logic src_hit(input logic [1:0] htype, input logic [4:0] rs,
                                   input logic store);
    logic hit;
    hit = 1'b0;
    case (htype)
      HAZARD_DECODE:
        hit = reg_match(rs, hz.rd_ex, hz.reg_we_ex, !hz.rd_complete_ex) ||
              reg_match(rs, hz.rd_mem, hz.reg_we_mem, hz.mem_rd_en_mem);
      HAZARD_EXECUTE:
        hit = reg_match(rs, hz.rd_ex, hz.reg_we_ex, hz.mem_rd_en_ex && !store);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [4:0]           rs2_eff;
  logic                 stall;
  logic                 exception;
  logic [CNT_WIDTH-1:0] stall_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rs2_eff   = hz.rs_used ? hz.rs2_id : 5'd0;
    exception = (hz.hazard_type == HAZARD_EXCEPTION);
    // A store only reads rs2 as write data, so only rs2 gets the store exemption.
    stall     = src_hit(hz.hazard_type, hz.rs1_id, 1'b0) ||
                src_hit(hz.hazard_type, rs2_eff, hz.store_id);
  end

  assign hz.stall_if = stall;
  assign hz.stall_id = stall;
  assign hz.flush_id = exception;
  assign hz.flush_ex = stall || exception;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_WIDTH{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) stall_count_q <= '0;
    else          stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit_ctrl.sv
// Self-checking bench for hazard_unit_ctrl: directed test-plan steps followed by
// random stimulus, both compared against a rule-level reference model.
module tb_hazard_unit_ctrl;

  typedef struct packed {
    logic [1:0] ht;
    logic       rs_used;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd_ex;
    logic [4:0] rd_mem;
    logic       we_ex;
    logic       we_mem;
    logic       ld_ex;
    logic       ld_mem;
    logic       store;
    logic       cpl;
  } stim_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] cnt32;
  logic [1:0]  cnt2;
  int          tests = 0;
  int          fails = 0;
  int unsigned exp_cnt32;
  int unsigned exp_cnt2;

  hazard_unit_ctrl_if hz32 ();
  hazard_unit_ctrl_if hz2 ();

  hazard_unit_ctrl #(.CNT_WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .hz(hz32), .stall_count(cnt32));
  hazard_unit_ctrl #(.CNT_WIDTH(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .hz(hz2), .stall_count(cnt2));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: does any source operand read a value still being produced?
  // Returns {stall, flush_id, flush_ex}.
  function automatic logic [2:0] model(input stim_t s);
    logic [4:0] srcs [2];
    logic       is_store_data [2];
    logic       stall;
    stall = 1'b0;
    srcs[0] = s.rs1; is_store_data[0] = 1'b0;
    srcs[1] = s.rs2; is_store_data[1] = s.store;
    for (int k = 0; k < 2; k++) begin
      if (k == 1 && !s.rs_used) continue;
      if (srcs[k] == 0) continue;
      if (s.ht == 2'd1) begin
        if (s.we_ex && !s.cpl && s.rd_ex == srcs[k]) stall = 1'b1;
        if (s.we_mem && s.ld_mem && s.rd_mem == srcs[k]) stall = 1'b1;
      end else if (s.ht == 2'd2) begin
        if (s.we_ex && s.ld_ex && !is_store_data[k] && s.rd_ex == srcs[k]) stall = 1'b1;
      end
    end
    if (s.ht == 2'd3) return 3'b011;
    return {stall, 1'b0, stall};
  endfunction

  task automatic drive(input stim_t s);
    hz32.hazard_type = s.ht;     hz2.hazard_type = s.ht;
    hz32.rs_used = s.rs_used;    hz2.rs_used = s.rs_used;
    hz32.rs1_id = s.rs1;         hz2.rs1_id = s.rs1;
    hz32.rs2_id = s.rs2;         hz2.rs2_id = s.rs2;
    hz32.rd_ex = s.rd_ex;        hz2.rd_ex = s.rd_ex;
    hz32.rd_mem = s.rd_mem;      hz2.rd_mem = s.rd_mem;
    hz32.reg_we_ex = s.we_ex;    hz2.reg_we_ex = s.we_ex;
    hz32.reg_we_mem = s.we_mem;  hz2.reg_we_mem = s.we_mem;
    hz32.mem_rd_en_ex = s.ld_ex; hz2.mem_rd_en_ex = s.ld_ex;
    hz32.mem_rd_en_mem = s.ld_mem; hz2.mem_rd_en_mem = s.ld_mem;
    hz32.store_id = s.store;     hz2.store_id = s.store;
    hz32.rd_complete_ex = s.cpl; hz2.rd_complete_ex = s.cpl;
  endtask

  // One cycle: drive at negedge, check comb outputs, clock, check counters.
  task automatic step(input string tag, input stim_t s, input logic rst_n);
    logic [2:0] e;
    @(negedge clock);
    drive(s);
    reset_n = rst_n;
    #1;
    e = model(s);
    check({tag, ".ctrl"}, {hz32.stall_if, hz32.stall_id, hz32.flush_id, hz32.flush_ex},
          {e[2], e[2], e[1], e[0]});
    check({tag, ".ctrl2"}, {hz2.stall_if, hz2.flush_id, hz2.flush_ex}, e);
    if (!rst_n) begin
      exp_cnt32 = 0;
      exp_cnt2  = 0;
    end else if (e[2]) begin
      if (exp_cnt32 != 32'hFFFF_FFFF) exp_cnt32++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    @(posedge clock);
    #1;
    check({tag, ".cnt32"}, cnt32, exp_cnt32);
    check({tag, ".cnt2"}, {30'd0, cnt2}, exp_cnt2);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.ht      = 2'($urandom_range(0, 3));
    s.rs_used = 1'($urandom);
    s.rs1     = 5'($urandom_range(0, 3));
    s.rs2     = 5'($urandom_range(0, 3));
    s.rd_ex   = 5'($urandom_range(0, 3));
    s.rd_mem  = 5'($urandom_range(0, 3));
    s.we_ex   = 1'($urandom);
    s.we_mem  = 1'($urandom);
    s.ld_ex   = 1'($urandom);
    s.ld_mem  = 1'($urandom);
    s.store   = 1'($urandom);
    s.cpl     = 1'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;
    reset_n = 1'b0;

    step("reset", idle, 1'b0);
    check("reset.zero", cnt32, 32'd0);

    s = '0; s.ht = 2'd1; s.rs1 = 5'd5; s.rd_ex = 5'd5; s.we_ex = 1'b1;
    for (int i = 0; i < 4; i++) step("dec_ex", s, 1'b1);
    step("idle", idle, 1'b1);
    step("idle", idle, 1'b1);
    check("cnt_after_4", cnt32, 32'd4);
    step("dec_ex5", s, 1'b1);
    check("cnt2_sat", {30'd0, cnt2}, 32'd3);
    s.cpl = 1'b1; s.rd_mem = 5'd9;
    step("dec_ex_cpl", s, 1'b1);

    s = '0; s.ht = 2'd1; s.rs2 = 5'd7; s.rs_used = 1'b1; s.rd_mem = 5'd7;
    s.we_mem = 1'b1; s.ld_mem = 1'b1;
    step("dec_mem", s, 1'b1);
    s.rs_used = 1'b0;
    step("dec_mem_rs1only", s, 1'b1);
    s.rs_used = 1'b1; s.ld_mem = 1'b0;
    step("dec_mem_noload", s, 1'b1);

    s = '0; s.ht = 2'd2; s.rs2 = 5'd3; s.rs_used = 1'b1; s.rd_ex = 5'd3;
    s.we_ex = 1'b1; s.ld_ex = 1'b1; s.store = 1'b1;
    step("ex_store_rs2", s, 1'b1);
    s.store = 1'b0;
    step("ex_load_rs2", s, 1'b1);
    s.store = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd1;
    step("ex_store_rs1", s, 1'b1);

    s = '0; s.we_ex = 1'b1; s.ld_ex = 1'b1; s.we_mem = 1'b1; s.ld_mem = 1'b1;
    for (int t = 0; t < 3; t++) begin
      s.ht = 2'(t);
      step("x0", s, 1'b1);
    end

    s = '0; s.rs1 = 5'd4; s.rs2 = 5'd4; s.rs_used = 1'b1; s.rd_ex = 5'd4;
    s.rd_mem = 5'd4; s.we_ex = 1'b1; s.we_mem = 1'b1; s.ld_ex = 1'b1; s.ld_mem = 1'b1;
    s.ht = 2'd3;
    step("exception", s, 1'b1);
    s.ht = 2'd0;
    step("nohazard", s, 1'b1);

    s.ht = 2'd1;
    step("rst_prio", s, 1'b0);

    for (int i = 0; i < 300; i++)
      step("rand", rand_stim(), ($urandom_range(0, 19) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
